// File: rtl/mips_prog_loader.sv
// Framed byte-stream loader for the pipelined MIPS32 core.
// Writes words into unified memory, then releases the core at the frame base.
module mips_prog_loader #(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic [ADDR_W-1:0] pc_init,
  output logic              err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [3:0] {
    IDLE,
    BASE_HI,
    BASE_LO,
    CNT_HI,
    CNT_LO,
    DATA,
    START,
    RUN,
    FAIL
  } state_t;

  localparam logic [16:0] MEM_WORDS = 17'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE =
    {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_n;
  logic [7:0]        base_hi_q, base_hi_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [7:0]        cnt_hi_q, cnt_hi_n;
  logic [15:0]       cnt_q, cnt_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [23:0]       buf_q, buf_n;
  logic [1:0]        idx_q, idx_n;

  logic              in_ready_n;
  logic              mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [31:0]       mem_wdata_n;
  logic              cpu_hold_n;
  logic              cpu_start_n;
  logic [ADDR_W-1:0] pc_init_n;
  logic              err_n;
  logic [15:0]       wl_n;

  logic              acc;
  logic              is_sync;
  logic [15:0]       cnt_w;
  logic [16:0]       span;
  logic [31:0]       word_w;

  assign acc     = in_valid && in_ready;
  assign is_sync = (in_data == SYNC_BYTE);
  assign cnt_w   = {cnt_hi_q, in_data};
  assign span    = 17'(base_q) + 17'(cnt_w);
  assign word_w  = {buf_q, in_data};

  always_comb begin
    state_n     = state_q;
    base_hi_n   = base_hi_q;
    base_n      = base_q;
    cnt_hi_n    = cnt_hi_q;
    cnt_n       = cnt_q;
    addr_n      = addr_q;
    buf_n       = buf_q;
    idx_n       = idx_q;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    err_n       = err;
    wl_n        = words_loaded;

    unique case (state_q)
      IDLE, RUN, FAIL: begin
        if (acc && is_sync) begin
          state_n = BASE_HI;
          err_n   = 1'b0;
          wl_n    = 16'd0;
        end
      end
      BASE_HI: begin
        if (acc) begin
          base_hi_n = in_data;
          state_n   = BASE_LO;
        end
      end
      BASE_LO: begin
        if (acc) begin
          base_n  = ADDR_W'({base_hi_q, in_data});
          state_n = CNT_HI;
        end
      end
      CNT_HI: begin
        if (acc) begin
          cnt_hi_n = in_data;
          state_n  = CNT_LO;
        end
      end
      CNT_LO: begin
        if (acc) begin
          cnt_n = cnt_w;
          // Reject frames that would run past the top of memory.
          if (span > MEM_WORDS) begin
            err_n   = 1'b1;
            state_n = FAIL;
          end else if (cnt_w == 16'd0) begin
            state_n = START;
          end else begin
            addr_n  = base_q;
            idx_n   = 2'd0;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        // Hold off START until the last write strobe has been seen.
        if (mem_we && (words_loaded == cnt_q)) begin
          state_n = START;
        end else if (acc) begin
          if (idx_q == 2'd3) begin
            mem_we_n    = 1'b1;
            mem_addr_n  = addr_q;
            mem_wdata_n = word_w;
            addr_n      = addr_q + ADDR_ONE;
            wl_n        = words_loaded + 16'd1;
            idx_n       = 2'd0;
          end else begin
            buf_n = {buf_q[15:0], in_data};
            idx_n = idx_q + 2'd1;
          end
        end
      end
      START: begin
        state_n = RUN;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    in_ready_n  = (state_n != START);
    cpu_start_n = (state_n == START);
    cpu_hold_n  = !((state_n == START) || (state_n == RUN));
    pc_init_n   = (state_n == START) ? base_q : pc_init;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_hi_q <= '0;
      base_q    <= '0;
      cnt_hi_q  <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      buf_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_n;
      base_hi_q <= base_hi_n;
      base_q    <= base_n;
      cnt_hi_q  <= cnt_hi_n;
      cnt_q     <= cnt_n;
      addr_q    <= addr_n;
      buf_q     <= buf_n;
      idx_q     <= idx_n;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      cpu_start    <= 1'b0;
      pc_init      <= '0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      in_ready     <= in_ready_n;
      mem_we       <= mem_we_n;
      mem_addr     <= mem_addr_n;
      mem_wdata    <= mem_wdata_n;
      cpu_hold     <= cpu_hold_n;
      cpu_start    <= cpu_start_n;
      pc_init      <= pc_init_n;
      err          <= err_n;
      words_loaded <= wl_n;
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed scoreboard bench for mips_prog_loader.
// Expected writes and start PCs are queued as frames are sent.
`timescale 1ns/1ps
module tb_mips_prog_loader;

  logic        clk1;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        cpu_start;
  logic [9:0]  pc_init;
  logic        err;
  logic [15:0] words_loaded;

  mips_prog_loader #(
    .ADDR_W   (10),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_hold    (cpu_hold),
    .cpu_start   (cpu_start),
    .pc_init     (pc_init),
    .err         (err),
    .words_loaded(words_loaded)
  );

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  int          checks;
  int          errors;
  wr_t         wq[$];
  logic [9:0]  pq[$];
  logic [31:0] payload[$];
  wr_t         e_wr;
  logic [9:0]  e_pc;

  localparam logic [31:0] PROG [11] = '{
    32'h28010078, 32'h0c631800, 32'h0c631800, 32'h20220000,
    32'h0c631800, 32'h0c631800, 32'h2842002d, 32'h0c631800,
    32'h0c631800, 32'h24220001, 32'hfc000000
  };

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #200000;
    $display("FAIL global_timeout errors=%0d", errors);
    $fatal(1, "timeout");
  end

  always @(negedge clk1) begin
    if (rst_n) begin
      if (mem_we) begin
        checks++;
        assert (wq.size() > 0) else begin
          errors++;
          $error("FAIL wr_unexpected: addr=%0d data=%h, none expected",
                 mem_addr, mem_wdata);
        end
        if (wq.size() > 0) begin
          e_wr = wq.pop_front();
          checks++;
          assert ({mem_addr, mem_wdata} === {e_wr.a, e_wr.d}) else begin
            errors++;
            $error("FAIL wr_data: got %0d:%h expected %0d:%h",
                   mem_addr, mem_wdata, e_wr.a, e_wr.d);
          end
        end
      end
      if (cpu_start) begin
        checks++;
        assert (pq.size() > 0) else begin
          errors++;
          $error("FAIL start_unexpected: pc_init=%0d", pc_init);
        end
        if (pq.size() > 0) begin
          e_pc = pq.pop_front();
          checks++;
          assert (pc_init === e_pc) else begin
            errors++;
            $error("FAIL pc_init: got %0d expected %0d", pc_init, e_pc);
          end
        end
        checks++;
        assert ({cpu_hold, mem_we} === 2'b00) else begin
          errors++;
          $error("FAIL start_cycle: hold/we got %b expected 00",
                 {cpu_hold, mem_we});
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int stall);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk1);
      if (stall > 0 && $urandom_range(99) < stall) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        ok       = in_ready;
      end
      n++;
    end
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL send_timeout: byte %h not accepted", b);
    end
  endtask

  task automatic settle();
    @(negedge clk1);
    in_valid = 1'b0;
    repeat (6) @(negedge clk1);
    check("wq_drained", wq.size(), 0);
    check("pq_drained", pq.size(), 0);
  endtask

  task automatic frame(input logic [15:0] base, input logic [15:0] cnt,
                       input bit good, input int stall);
    wr_t w;
    send(8'hA5, stall);
    send(base[15:8], stall);
    send(base[7:0], stall);
    send(cnt[15:8], stall);
    send(cnt[7:0], stall);
    if (good) pq.push_back(base[9:0]);
    for (int i = 0; i < payload.size(); i++) begin
      w.a = 10'(base + 16'(i));
      w.d = payload[i];
      if (good) wq.push_back(w);
      for (int k = 3; k >= 0; k--) send(payload[i][8*k +: 8], stall);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk1);
    check("rst_in_ready", in_ready, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_outs", {mem_we, cpu_start, err}, 0);
    check("rst_vals", {mem_addr, mem_wdata, pc_init}, 0);
    check("rst_wl", words_loaded, 0);
    rst_n = 1'b1;
    @(negedge clk1);
    check("ready_after_rst", in_ready, 1);

    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h12, 0);
    settle();
    check("garbage_hold", cpu_hold, 1);
    check("garbage_err", err, 0);

    payload = '{32'h00000055};
    frame(16'h0078, 16'd1, 1'b1, 0);
    settle();
    check("data_wl", words_loaded, 1);
    check("data_hold", cpu_hold, 0);

    payload.delete();
    for (int i = 0; i < 11; i++) payload.push_back(PROG[i]);
    send(8'hA5, 0);
    @(negedge clk1);
    in_valid = 1'b0;
    check("reload_hold", cpu_hold, 1);
    check("reload_wl_clr", words_loaded, 0);
    send(8'h00, 40);
    send(8'h00, 40);
    send(8'h00, 40);
    send(8'h0B, 40);
    pq.push_back(10'd0);
    for (int i = 0; i < 11; i++) begin
      e_wr.a = 10'(i);
      e_wr.d = PROG[i];
      wq.push_back(e_wr);
      for (int k = 3; k >= 0; k--) send(PROG[i][8*k +: 8], 40);
    end
    settle();
    check("prog_wl", words_loaded, 11);
    check("prog_hold", cpu_hold, 0);

    payload.delete();
    frame(16'h03FF, 16'd2, 1'b0, 0);
    @(negedge clk1);
    in_valid = 1'b0;
    check("ovf_err", err, 1);
    check("ovf_hold", cpu_hold, 1);
    for (int i = 0; i < 8; i++) send(8'(i * 17), 0);
    settle();
    check("ovf_err_sticky", err, 1);
    check("ovf_hold_stays", cpu_hold, 1);

    frame(16'h0010, 16'd0, 1'b1, 0);
    settle();
    check("cnt0_err_clr", err, 0);
    check("cnt0_wl", words_loaded, 0);
    check("cnt0_hold", cpu_hold, 0);

    payload = '{32'hA5A5A5A5, 32'h12A5FF00};
    frame(16'h0020, 16'd2, 1'b1, 60);
    settle();
    check("a5_wl", words_loaded, 2);

    e_wr.a = 10'h040;
    e_wr.d = 32'h11223344;
    wq.push_back(e_wr);
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h40, 0);
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    send(8'h55, 0);
    send(8'h66, 0);
    @(negedge clk1);
    in_valid = 1'b0;
    check("mid_wl", words_loaded, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hold", cpu_hold, 1);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_outs", {mem_we, cpu_start, err}, 0);
    check("mid_rst_wl", words_loaded, 0);
    check("mid_rst_addr", {mem_addr, mem_wdata}, 0);
    wq.delete();
    pq.delete();
    @(negedge clk1);
    rst_n = 1'b1;
    payload = '{32'hDEADBEEF, 32'h0BADF00D};
    frame(16'h0040, 16'd2, 1'b1, 20);
    settle();
    check("post_rst_wl", words_loaded, 2);
    check("post_rst_hold", cpu_hold, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Upstream program/data loader for the pipelined MIPS32 core. Receives a framed byte stream and writes 32-bit words into the core's unified memory.
- Holds the core halted while loading, then releases it with a one-cycle start pulse and the initial PC.
- Replaces hand-poking of memory, PC and HALTED from benches; the same frames can come from a UART receiver on silicon.

Parameters:
- ADDR_W, 10, word-address width of core memory (1024 words).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk1  in  1  clock; loader runs on the core's phase-1 clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle; a byte transfers when in_valid && in_ready
- mem_we  out  1  one-cycle word write strobe
- mem_addr  out  ADDR_W  word address for the write
- mem_wdata  out  32  write data
- cpu_hold  out  1  drives core HALTED; 1 = core frozen
- cpu_start  out  1  one-cycle pulse; core loads PC from pc_init and clears TAKEN_BRANCH
- pc_init  out  ADDR_W  start PC (= frame base address)
- err  out  1  sticky frame error
- words_loaded  out  16  words written in the current frame

Behaviour:
- Reset (async, rst_n=0): in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, cpu_start=0, pc_init=0, err=0, words_loaded=0, state=IDLE.
- Frame format, big-endian: SYNC, BASE[15:8], BASE[7:0], CNT[15:8], CNT[7:0], then 4*CNT data bytes (MSB first per word). Only BASE[ADDR_W-1:0] is used.
- States: IDLE, BASE_HI, BASE_LO, CNT_HI, CNT_LO, DATA, START, RUN, FAIL.
- in_ready=1 in every state except START; it is 0 during reset.
- IDLE: non-sync bytes are consumed and dropped. SYNC moves to BASE_HI and clears err and words_loaded. cpu_hold stays 1.
- BASE_HI to CNT_LO: each accepted byte advances one state.
  - On CNT_LO, the loader checks whether BASE+CNT > 2^ADDR_W, computed at 17 bits, no wrap.
  - If true, it sets err=1 and goes to FAIL.
  - Otherwise, if CNT=0, it goes to START.
  - Otherwise it goes to DATA with the address counter = BASE.
- DATA: a 2-bit byte index assembles the word.
  - On the 4th byte, the next cycle presents mem_we=1 with mem_addr=current address and mem_wdata=the assembled word, for exactly one cycle.
  - The address then increments and words_loaded increments.
  - After word CNT is written, the state goes to START.
  - A new byte may be accepted in the same cycle mem_we is high, so throughput is 1 byte/cycle.
- START (1 cycle): cpu_start=1, pc_init=BASE, cpu_hold drops to 0 in the same cycle. Then RUN.
- RUN: cpu_hold=0. Non-sync bytes are dropped. SYNC reasserts cpu_hold=1 on the next edge and enters BASE_HI (reload; the core is frozen mid-execution).
- FAIL: consumes and drops all bytes except SYNC, which restarts the frame as in IDLE. cpu_hold stays 1, and no mem_we is ever issued from a failed frame.
- SYNC inside DATA or a header state is treated as data, not as a restart.
- in_valid=0 stalls any state with no side effects. Partial words are held indefinitely.
- rst_n asserted mid-frame: all progress is lost, no further mem_we, cpu_hold=1 immediately (asynchronously).
- mem_we and cpu_start are never high in the same cycle.

Test Plan:
- Frame A5 00 00 00 0B followed by the 11 program words (28010078, 0c631800, 0c631800, 20220000, 0c631800, 0c631800, 2842002d, 0c631800, 0c631800, 24220001, fc000000):
  - 11 mem_we pulses at addresses 0..10 with those data values;
  - cpu_start single pulse with pc_init=0;
  - cpu_hold 1 -> 0;
  - words_loaded=11.
- Data frame then program frame:
  - First frame A5 00 78 00 01 00 00 00 55 writes Mem[120]=85.
  - It is sent before the program frame, and the bench holds the core until the program frame finishes.
  - Integrated with the core, Mem[121] = 130 after HLT.
- Overflow: A5 03 FF 00 02 -> err=1, state FAIL; the next 8 bytes produce no mem_we; cpu_hold stays 1. A following valid frame clears err.
- CNT=0: A5 00 10 00 00 -> no mem_we, cpu_start pulse with pc_init=16.
- Stalls and byte values:
  - Drop in_valid randomly inside a data word; the assembled word must still be correct.
  - A data byte equal to A5 must be written as data.
  - Garbage bytes 00 FF 12 in IDLE are ignored.
- Reset mid-frame after 6 data bytes -> outputs return to reset values immediately; a new full frame loads correctly with words_loaded counting from 0.
